// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the control pipeline slice.
//   - Bit positions of the fields inside the decoder's 8-bit control word.
//   - ALU operation codes. ALU_NOP is the op driven for bubbles and at reset.
//   - Encodings of the EX operand forwarding mux selects.
//   - Small field-extraction helpers for the control word.
// -----------------------------------------------------------------------------
package ctrl_pkg;

   localparam int CTRL_W   = 8;

   // Control word layout
   localparam int SELA_LSB = 0;   // [1:0] operand A source select
   localparam int SELB_LSB = 2;   // [3:2] operand B source select
   localparam int MEMRD    = 4;   // load
   localparam int MEMWR    = 5;   // store
   localparam int REGWR    = 6;   // writes the register file
   localparam int DATASEL  = 7;   // 0 = memory data, 1 = ALU result

   // ALU operation codes
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_NOP = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   // Forwarding mux selects for the EX operands
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,   // value read from the register file in ID
      FWD_MEM = 2'b01,   // result held in EX/MEM
      FWD_WB  = 2'b10    // result held in MEM/WB
   } fwd_sel_e;

   // Field extraction helpers
   function automatic logic [1:0] ctrl_sel_a(input logic [CTRL_W-1:0] ctrl);
      return ctrl[SELA_LSB +: 2];
   endfunction

   function automatic logic [1:0] ctrl_sel_b(input logic [CTRL_W-1:0] ctrl);
      return ctrl[SELB_LSB +: 2];
   endfunction

endpackage : ctrl_pkg

// File: rtl/ctrl_pipe_stage_hazard.sv
// -----------------------------------------------------------------------------
// ctrl_hazard_unit
// Purely combinational hazard logic for the control pipeline.
//   stall  : load-use hazard between the load in EX and the instruction in ID.
//   fwd_a  : forwarding select for EX operand A (from ex_rs).
//   fwd_b  : forwarding select for EX operand B (from ex_rt).
// Ports
//   id_rs, id_rt, id_rs_used, id_rt_used : source operands of the ID instruction
//   ex_mem_read, ex_rd                   : load flag / destination in EX
//   ex_rs, ex_rt                         : source operands of the EX instruction
//   mem_reg_write, mem_rd                : producer in EX/MEM
//   wb_reg_write, wb_rd                  : producer in MEM/WB
// -----------------------------------------------------------------------------
module ctrl_hazard_unit
   import ctrl_pkg::*;
#(
   parameter int unsigned REG_AW = 3
)(
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] ex_rs,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_rd,
   output logic              stall,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
);

   // A load result only exists after MEM, so a dependent instruction in ID
   // has to wait one cycle; after that the value is picked up from MEM/WB.
   always_comb begin
      stall = ex_mem_read &
              ((id_rs_used & (id_rs == ex_rd)) |
               (id_rt_used & (id_rt == ex_rd)));
   end

   // The MEM stage holds the younger producer, so it wins over WB.
   always_comb begin
      fwd_a = FWD_RF;
      if (mem_reg_write && (mem_rd == ex_rs)) begin
         fwd_a = FWD_MEM;
      end else if (wb_reg_write && (wb_rd == ex_rs)) begin
         fwd_a = FWD_WB;
      end
   end

   always_comb begin
      fwd_b = FWD_RF;
      if (mem_reg_write && (mem_rd == ex_rt)) begin
         fwd_b = FWD_MEM;
      end else if (wb_reg_write && (wb_rd == ex_rt)) begin
         fwd_b = FWD_WB;
      end
   end

endmodule : ctrl_hazard_unit

// File: rtl/ctrl_pipe_stage.sv
// -----------------------------------------------------------------------------
// ctrl_pipe_stage
// Carries the decoder's 8-bit control word through the ID/EX, EX/MEM and
// MEM/WB boundaries and fans it out as per-stage control. Inserts a bubble
// into EX on a load-use stall or on a branch/jump flush, and selects EX
// operand forwarding sources.
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   id_ctrl, id_alu_op: control word and ALU op of the instruction in ID
//   id_rs/rt/rd       : register addresses of the ID instruction
//   id_rs/rt_used     : ID instruction actually reads rs/rt
//   flush_id          : squash the ID instruction (branch taken / jump)
//   stall             : combinational load-use stall (holds PC and IF/ID)
//   ex_*              : EX-stage selA/selB, ALU op, destination
//   fwd_a, fwd_b      : forwarding selects for ALU operands A/B
//   mem_*             : MEM-stage memRead/memWrite, destination
//   wb_*              : WB-stage regWrite/dataSel, destination
// -----------------------------------------------------------------------------
module ctrl_pipe_stage
   import ctrl_pkg::*;
#(
   parameter int unsigned REG_AW  = 3,
   parameter logic [3:0]  NOP_ALU = ALU_NOP
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        id_ctrl,
   input  logic [3:0]        id_alu_op,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic              flush_id,
   output logic              stall,
   output logic [1:0]        ex_sel_a,
   output logic [1:0]        ex_sel_b,
   output logic [3:0]        ex_alu_op,
   output logic [REG_AW-1:0] ex_rd,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              mem_read,
   output logic              mem_write,
   output logic [REG_AW-1:0] mem_rd,
   output logic              wb_reg_write,
   output logic              wb_data_sel,
   output logic [REG_AW-1:0] wb_rd
);

   // ---------------- EX stage (ID/EX register) ----------------
   logic [7:0]        ex_ctrl_q,   ex_ctrl_d;
   logic [3:0]        ex_alu_op_q, ex_alu_op_d;
   logic [REG_AW-1:0] ex_rs_q,     ex_rs_d;
   logic [REG_AW-1:0] ex_rt_q,     ex_rt_d;
   logic [REG_AW-1:0] ex_rd_q,     ex_rd_d;

   // ---------------- MEM stage (EX/MEM register) ----------------
   logic              mem_read_q,      mem_read_d;
   logic              mem_write_q,     mem_write_d;
   logic              mem_reg_write_q, mem_reg_write_d;
   logic              mem_data_sel_q,  mem_data_sel_d;
   logic [REG_AW-1:0] mem_rd_q,        mem_rd_d;

   // ---------------- WB stage (MEM/WB register) ----------------
   logic              wb_reg_write_q, wb_reg_write_d;
   logic              wb_data_sel_q,  wb_data_sel_d;
   logic [REG_AW-1:0] wb_rd_q,        wb_rd_d;

   logic stall_w;
   logic bubble_w;

   ctrl_hazard_unit #(
      .REG_AW (REG_AW)
   ) u_hazard (
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_rs_used    (id_rs_used),
      .id_rt_used    (id_rt_used),
      .ex_mem_read   (ex_ctrl_q[MEMRD]),
      .ex_rd         (ex_rd_q),
      .ex_rs         (ex_rs_q),
      .ex_rt         (ex_rt_q),
      .mem_reg_write (mem_reg_write_q),
      .mem_rd        (mem_rd_q),
      .wb_reg_write  (wb_reg_write_q),
      .wb_rd         (wb_rd_q),
      .stall         (stall_w),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b)
   );

   // A stall and a flush both replace the ID instruction with a bubble.
   // When both are set the stall is what the front end sees (PC and IF/ID
   // hold), so the branch in ID resolves again on the following cycle.
   assign bubble_w = stall_w | flush_id;

   always_comb begin
      ex_ctrl_d   = id_ctrl;
      ex_alu_op_d = id_alu_op;
      ex_rs_d     = id_rs;
      ex_rt_d     = id_rt;
      ex_rd_d     = id_rd;
      if (rst || bubble_w) begin
         // Bubble and reset contents are identical for EX.
         ex_ctrl_d   = '0;
         ex_alu_op_d = NOP_ALU;
         ex_rs_d     = '0;
         ex_rt_d     = '0;
         ex_rd_d     = '0;
      end
   end

   always_comb begin
      mem_read_d      = ex_ctrl_q[MEMRD];
      mem_write_d     = ex_ctrl_q[MEMWR];
      mem_reg_write_d = ex_ctrl_q[REGWR];
      mem_data_sel_d  = ex_ctrl_q[DATASEL];
      mem_rd_d        = ex_rd_q;
      if (rst) begin
         mem_read_d      = 1'b0;
         mem_write_d     = 1'b0;
         mem_reg_write_d = 1'b0;
         mem_data_sel_d  = 1'b0;
         mem_rd_d        = '0;
      end
   end

   always_comb begin
      wb_reg_write_d = mem_reg_write_q;
      wb_data_sel_d  = mem_data_sel_q;
      wb_rd_d        = mem_rd_q;
      if (rst) begin
         wb_reg_write_d = 1'b0;
         wb_data_sel_d  = 1'b0;
         wb_rd_d        = '0;
      end
   end

   always_ff @(posedge clk) begin
      ex_ctrl_q       <= ex_ctrl_d;
      ex_alu_op_q     <= ex_alu_op_d;
      ex_rs_q         <= ex_rs_d;
      ex_rt_q         <= ex_rt_d;
      ex_rd_q         <= ex_rd_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_reg_write_q <= mem_reg_write_d;
      mem_data_sel_q  <= mem_data_sel_d;
      mem_rd_q        <= mem_rd_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_data_sel_q   <= wb_data_sel_d;
      wb_rd_q         <= wb_rd_d;
   end

   // ---------------- Output fan-out ----------------
   assign stall        = stall_w;
   assign ex_sel_a     = ctrl_sel_a(ex_ctrl_q);
   assign ex_sel_b     = ctrl_sel_b(ex_ctrl_q);
   assign ex_alu_op    = ex_alu_op_q;
   assign ex_rd        = ex_rd_q;
   assign mem_read     = mem_read_q;
   assign mem_write    = mem_write_q;
   assign mem_rd       = mem_rd_q;
   assign wb_reg_write = wb_reg_write_q;
   assign wb_data_sel  = wb_data_sel_q;
   assign wb_rd        = wb_rd_q;

endmodule : ctrl_pipe_stage

// File: tb/tb_ctrl_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_ctrl_pipe_stage
// Directed scenarios from the test plan followed by a randomized run checked
// against a queue-style model of the instructions occupying EX, MEM and WB.
// -----------------------------------------------------------------------------
module tb_ctrl_pipe_stage;

   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    id_ctrl;
   logic [3:0]    id_alu_op;
   logic [AW-1:0] id_rs, id_rt, id_rd;
   logic          id_rs_used, id_rt_used, flush_id;
   logic          stall;
   logic [1:0]    ex_sel_a, ex_sel_b;
   logic [3:0]    ex_alu_op;
   logic [AW-1:0] ex_rd;
   logic [1:0]    fwd_a, fwd_b;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_rd;
   logic          wb_reg_write, wb_data_sel;
   logic [AW-1:0] wb_rd;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ctrl_pipe_stage #(.REG_AW(AW), .NOP_ALU(4'b0110)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_ctrl      (id_ctrl),
      .id_alu_op    (id_alu_op),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rd        (id_rd),
      .id_rs_used   (id_rs_used),
      .id_rt_used   (id_rt_used),
      .flush_id     (flush_id),
      .stall        (stall),
      .ex_sel_a     (ex_sel_a),
      .ex_sel_b     (ex_sel_b),
      .ex_alu_op    (ex_alu_op),
      .ex_rd        (ex_rd),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_rd       (mem_rd),
      .wb_reg_write (wb_reg_write),
      .wb_data_sel  (wb_data_sel),
      .wb_rd        (wb_rd)
   );

   // Instruction as seen by the model: what the decoder produced for it.
   typedef struct packed {
      logic [7:0]    ctrl;
      logic [3:0]    op;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [AW-1:0] rd;
   } instr_t;

   localparam instr_t EMPTY = '{ctrl: 8'h00, op: 4'b0110, rs: 3'd0, rt: 3'd0, rd: 3'd0};

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [7:0] c, input logic [3:0] op,
                         input int rs, input int rt, input int rd,
                         input logic rsu, input logic rtu, input logic fl);
      id_ctrl    = c;
      id_alu_op  = op;
      id_rs      = AW'(rs);
      id_rt      = AW'(rt);
      id_rd      = AW'(rd);
      id_rs_used = rsu;
      id_rt_used = rtu;
      flush_id   = fl;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_id(8'h00, 4'b0110, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      set_id(8'hC5, 4'b0001, 1, 2, 5, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      n_cmp++;
      if ({ex_sel_a, ex_sel_b, ex_alu_op, ex_rd} !== {2'b00, 2'b00, 4'b0110, 3'd0}) begin
         n_fail++;
         $display("FAIL reset_ex got=%b_%b_%b_%0d exp=00_00_0110_0", ex_sel_a, ex_sel_b, ex_alu_op, ex_rd);
      end
      n_cmp++;
      if ({mem_read, mem_write, mem_rd, wb_reg_write, wb_data_sel, wb_rd} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_mem_wb got=%b%b_%0d_%b%b_%0d exp=all zero",
                  mem_read, mem_write, mem_rd, wb_reg_write, wb_data_sel, wb_rd);
      end
      n_cmp++;
      if ({stall, fwd_a, fwd_b} !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_comb got stall=%b fwd_a=%b fwd_b=%b exp=0/00/00", stall, fwd_a, fwd_b);
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if ({ex_sel_a, ex_sel_b} !== 4'b0101) begin
         n_fail++;
         $display("FAIL reset_release got sel_a=%b sel_b=%b exp=01/01", ex_sel_a, ex_sel_b);
      end
      $display("test_reset done");
   endtask

   task automatic test_add_flow();
      do_reset();
      set_id(8'hC5, 4'b0001, 0, 0, 3, 1'b0, 1'b0, 1'b0);
      tick();
      n_cmp++;
      if ({ex_alu_op, ex_rd} !== {4'b0001, 3'd3}) begin
         n_fail++;
         $display("FAIL add_ex got op=%b rd=%0d exp op=0001 rd=3", ex_alu_op, ex_rd);
      end
      set_id(8'h00, 4'b0110, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      tick();
      n_cmp++;
      if ({mem_read, mem_write, mem_rd} !== {1'b0, 1'b0, 3'd3}) begin
         n_fail++;
         $display("FAIL add_mem got rd=%b wr=%b rd=%0d exp 0/0/3", mem_read, mem_write, mem_rd);
      end
      tick();
      n_cmp++;
      if ({wb_reg_write, wb_data_sel, wb_rd} !== {1'b1, 1'b1, 3'd3}) begin
         n_fail++;
         $display("FAIL add_wb got rw=%b ds=%b rd=%0d exp 1/1/3", wb_reg_write, wb_data_sel, wb_rd);
      end
      $display("test_add_flow done");
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(8'h58, 4'b0010, 0, 0, 2, 1'b0, 1'b0, 1'b0);
      tick();
      set_id(8'hC5, 4'b0001, 2, 0, 5, 1'b1, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if (stall !== 1'b1) begin
         n_fail++;
         $display("FAIL load_use_stall got=%b exp=1", stall);
      end
      tick();
      n_cmp++;
      if ({ex_alu_op, ex_sel_a, ex_sel_b, ex_rd, stall} !== {4'b0110, 2'b00, 2'b00, 3'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL load_use_bubble got op=%b sa=%b sb=%b rd=%0d stall=%b exp 0110/00/00/0/0",
                  ex_alu_op, ex_sel_a, ex_sel_b, ex_rd, stall);
      end
      tick();
      n_cmp++;
      if ({ex_alu_op, ex_rd, fwd_a} !== {4'b0001, 3'd5, 2'b10}) begin
         n_fail++;
         $display("FAIL load_use_fwd got op=%b rd=%0d fwd_a=%b exp 0001/5/10", ex_alu_op, ex_rd, fwd_a);
      end
      $display("test_load_use done");
   endtask

   task automatic test_fwd_priority();
      for (int use_rt = 0; use_rt < 2; use_rt++) begin
         do_reset();
         set_id(8'hC5, 4'b0010, 0, 0, 4, 1'b0, 1'b0, 1'b0);
         tick();
         set_id(8'hC5, 4'b0010, 0, 0, 4, 1'b0, 1'b0, 1'b0);
         tick();
         if (use_rt == 0) set_id(8'hC5, 4'b0010, 4, 0, 1, 1'b1, 1'b0, 1'b0);
         else             set_id(8'hC5, 4'b0010, 0, 4, 1, 1'b0, 1'b1, 1'b0);
         tick();
         n_cmp++;
         if (use_rt == 0) begin
            if ({fwd_a, fwd_b} !== 4'b0100) begin
               n_fail++;
               $display("FAIL fwd_prio_a got fwd_a=%b fwd_b=%b exp 01/00", fwd_a, fwd_b);
            end
         end else begin
            if ({fwd_a, fwd_b} !== 4'b0001) begin
               n_fail++;
               $display("FAIL fwd_prio_b got fwd_a=%b fwd_b=%b exp 00/01", fwd_a, fwd_b);
            end
         end
      end
      $display("test_fwd_priority done");
   endtask

   task automatic test_flush();
      do_reset();
      set_id(8'hC5, 4'b0001, 1, 1, 7, 1'b0, 1'b0, 1'b1);
      tick();
      n_cmp++;
      if ({ex_alu_op, ex_sel_a, ex_sel_b, ex_rd} !== {4'b0110, 2'b00, 2'b00, 3'd0}) begin
         n_fail++;
         $display("FAIL flush_bubble got op=%b sa=%b sb=%b rd=%0d exp 0110/00/00/0",
                  ex_alu_op, ex_sel_a, ex_sel_b, ex_rd);
      end
      set_id(8'h00, 4'b0110, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      n_cmp++;
      if ({wb_reg_write, wb_rd} !== {1'b0, 3'd0}) begin
         n_fail++;
         $display("FAIL flush_no_wb got rw=%b rd=%0d exp 0/0", wb_reg_write, wb_rd);
      end
      // Stall and flush together
      set_id(8'h58, 4'b0010, 0, 0, 2, 1'b0, 1'b0, 1'b0);
      tick();
      set_id(8'hC5, 4'b0001, 2, 0, 6, 1'b1, 1'b0, 1'b1);
      #1;
      n_cmp++;
      if (stall !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_stall_held got=%b exp=1", stall);
      end
      tick();
      n_cmp++;
      if ({ex_alu_op, ex_rd} !== {4'b0110, 3'd0}) begin
         n_fail++;
         $display("FAIL flush_stall_bubble got op=%b rd=%0d exp 0110/0", ex_alu_op, ex_rd);
      end
      flush_id = 1'b0;
      tick();
      n_cmp++;
      if ({ex_alu_op, ex_rd} !== {4'b0001, 3'd6}) begin
         n_fail++;
         $display("FAIL flush_stall_resume got op=%b rd=%0d exp 0001/6", ex_alu_op, ex_rd);
      end
      $display("test_flush done");
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_id(8'h21, 4'b0010, 0, 0, 1, 1'b0, 1'b0, 1'b0);
      tick();
      set_id(8'hC5, 4'b0010, 0, 0, 3, 1'b0, 1'b0, 1'b0);
      tick();
      n_cmp++;
      if (mem_write !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_store_in_mem got=%b exp=1", mem_write);
      end
      rst = 1'b1;
      tick();
      n_cmp++;
      if ({mem_write, mem_read, mem_rd, ex_alu_op, ex_rd} !== {1'b0, 1'b0, 3'd0, 4'b0110, 3'd0}) begin
         n_fail++;
         $display("FAIL rst_mid_clear got mw=%b mr=%b mrd=%0d op=%b erd=%0d exp 0/0/0/0110/0",
                  mem_write, mem_read, mem_rd, ex_alu_op, ex_rd);
      end
      rst = 1'b0;
      set_id(8'h00, 4'b0110, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      tick();
      n_cmp++;
      if ({wb_reg_write, wb_data_sel, wb_rd} !== {1'b0, 1'b0, 3'd0}) begin
         n_fail++;
         $display("FAIL rst_mid_no_wb got rw=%b ds=%b rd=%0d exp 0/0/0", wb_reg_write, wb_data_sel, wb_rd);
      end
      $display("test_reset_mid done");
   endtask

   // Randomized run. The model keeps the instruction occupying each of
   // EX, MEM, WB (index 0..2) and shifts them along every cycle.
   task automatic test_random();
      instr_t pipe [3];
      instr_t cur;
      logic   exp_stall, fl, rsu, rtu;
      logic [1:0]  fa, fb;
      logic [24:0] exp_vec, got_vec;
      int cycles = 300;

      do_reset();
      for (int i = 0; i < 3; i++) pipe[i] = EMPTY;

      for (int c = 0; c < cycles; c++) begin
         rst      = ($urandom_range(0, 31) == 0);
         cur.ctrl = 8'($urandom_range(0, 255));
         cur.op   = 4'($urandom_range(0, 15));
         cur.rs   = AW'($urandom_range(0, 7));
         cur.rt   = AW'($urandom_range(0, 7));
         cur.rd   = AW'($urandom_range(0, 7));
         rsu      = 1'($urandom_range(0, 1));
         rtu      = 1'($urandom_range(0, 1));
         fl       = ($urandom_range(0, 7) == 0);
         set_id(cur.ctrl, cur.op, int'(cur.rs), int'(cur.rt), int'(cur.rd), rsu, rtu, fl);
         #1;

         // Load in EX whose destination the ID instruction reads.
         exp_stall = pipe[0].ctrl[4] &&
                     ((rsu && cur.rs == pipe[0].rd) || (rtu && cur.rt == pipe[0].rd));
         n_cmp++;
         if (stall !== exp_stall) begin
            n_fail++;
            $display("FAIL rand_stall cycle=%0d got=%b exp=%b", c, stall, exp_stall);
         end

         tick();

         if (rst) begin
            for (int i = 0; i < 3; i++) pipe[i] = EMPTY;
         end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (exp_stall || fl) ? EMPTY : cur;
         end

         // Nearest older writer of the EX source wins.
         fa = 2'b00;
         if (pipe[1].ctrl[6] && pipe[1].rd == pipe[0].rs)      fa = 2'b01;
         else if (pipe[2].ctrl[6] && pipe[2].rd == pipe[0].rs) fa = 2'b10;
         fb = 2'b00;
         if (pipe[1].ctrl[6] && pipe[1].rd == pipe[0].rt)      fb = 2'b01;
         else if (pipe[2].ctrl[6] && pipe[2].rd == pipe[0].rt) fb = 2'b10;

         exp_vec = {pipe[0].ctrl[1:0], pipe[0].ctrl[3:2], pipe[0].op, pipe[0].rd,
                    pipe[1].ctrl[4], pipe[1].ctrl[5], pipe[1].rd,
                    pipe[2].ctrl[6], pipe[2].ctrl[7], pipe[2].rd, fa, fb};
         got_vec = {ex_sel_a, ex_sel_b, ex_alu_op, ex_rd,
                    mem_read, mem_write, mem_rd,
                    wb_reg_write, wb_data_sel, wb_rd, fwd_a, fwd_b};
         n_cmp++;
         if (got_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL rand_stages cycle=%0d got=%b exp=%b", c, got_vec, exp_vec);
         end
      end
      rst = 1'b0;
      $display("test_random done (%0d cycles)", cycles);
   endtask

   initial begin
      rst = 1'b1;
      set_id(8'h00, 4'b0110, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_add_flow();
      test_load_use();
      test_fwd_priority();
      test_flush();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_ctrl_pipe_stage
